// File: rtl/bram_arbiter.sv
// bram_arbiter: two-port round-robin access sequencer for one single-port 512x32 BRAM.
// Define BRAM_ARB_PARITY_EN to drive byte parity on bram_dip and check bram_dop on reads.
module bram_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter bit RR     = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              perr0,
    output logic              perr1,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_di,
    output logic [3:0]        bram_dip,
    input  logic [DATA_W-1:0] bram_do,
    input  logic [3:0]        bram_dop
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t              state_q;
    logic                last_q;
    logic                id_q;
    logic                wr_q;
    logic                gnt0_q, gnt1_q;
    logic                done0_q, done1_q;
    logic                perr0_q, perr1_q;
    logic [DATA_W-1:0]   rdata0_q, rdata1_q;
    logic                bram_en_q, bram_we_q;
    logic [ADDR_W-1:0]   bram_addr_q;
    logic [DATA_W-1:0]   bram_di_q;
    logic [3:0]          bram_dip_q;

    logic                arb_ok;
    logic                win_d;
    logic                we_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   di_d;
    logic [3:0]          dip_d;
    logic                rd_perr;

`ifdef BRAM_ARB_PARITY_EN
    function automatic logic [3:0] bpar(input logic [31:0] d);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) begin
            p[i] = ^d[8*i +: 8];
        end
        return p;
    endfunction

    assign dip_d   = bpar(di_d);
    assign rd_perr = (bpar(bram_do) != bram_dop);
`else
    logic unused_dop;

    assign unused_dop = ^bram_dop;
    assign dip_d      = 4'd0;
    assign rd_perr    = 1'b0;
`endif

    // On a tie the port that did not win last time goes next (RR), else port 0.
    assign arb_ok = (req0 | req1) && (state_q != ISSUE);
    assign win_d  = (req0 & req1) ? (RR ? ~last_q : 1'b0) : req1;
    assign we_d   = win_d ? we1 : we0;
    assign addr_d = win_d ? addr1 : addr0;
    assign di_d   = win_d ? wdata1 : wdata0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            wr_q        <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            perr0_q     <= 1'b0;
            perr1_q     <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            bram_en_q   <= 1'b0;
            bram_we_q   <= 1'b0;
            bram_addr_q <= '0;
            bram_di_q   <= '0;
            bram_dip_q  <= 4'd0;
        end else begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            perr0_q <= 1'b0;
            perr1_q <= 1'b0;
            unique case (state_q)
                IDLE: state_q <= IDLE;
                ISSUE: begin
                    bram_en_q <= 1'b0;
                    bram_we_q <= 1'b0;
                    state_q   <= CAPTURE;
                end
                CAPTURE: begin
                    state_q <= IDLE;
                    if (id_q) begin
                        done1_q <= 1'b1;
                        if (!wr_q) begin
                            rdata1_q <= bram_do;
                            perr1_q  <= rd_perr;
                        end
                    end else begin
                        done0_q <= 1'b1;
                        if (!wr_q) begin
                            rdata0_q <= bram_do;
                            perr0_q  <= rd_perr;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
            // A new grant overrides the idle fallback chosen above.
            if (arb_ok) begin
                bram_en_q   <= 1'b1;
                bram_we_q   <= we_d;
                bram_addr_q <= addr_d;
                bram_di_q   <= di_d;
                bram_dip_q  <= dip_d;
                gnt0_q      <= ~win_d;
                gnt1_q      <= win_d;
                id_q        <= win_d;
                wr_q        <= we_d;
                last_q      <= win_d;
                state_q     <= ISSUE;
            end
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign perr0     = perr0_q;
    assign perr1     = perr1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign bram_en   = bram_en_q;
    assign bram_we   = bram_we_q;
    assign bram_addr = bram_addr_q;
    assign bram_di   = bram_di_q;
    assign bram_dip  = bram_dip_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: directed bench for bram_arbiter with a WRITE_FIRST BRAM model.
// A second fixed-priority instance covers RR=0.
module tb_bram_arbiter;

`ifdef BRAM_ARB_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        req0, req1, we0, we1;
    logic [8:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, done0, done1, perr0, perr1;
    logic [31:0] rdata0, rdata1;
    logic        bram_en, bram_we;
    logic [8:0]  bram_addr;
    logic [31:0] bram_di;
    logic [3:0]  bram_dip;
    logic [31:0] bram_do;
    logic [3:0]  bram_dop;

    logic [31:0] mem [512];
    logic [3:0]  pmem [512];
    logic [31:0] do_q;
    logic [3:0]  dop_q;
    logic        force_en;
    logic [3:0]  force_dop;

    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) begin
                mem[bram_addr]  <= bram_di;
                pmem[bram_addr] <= bram_dip;
                do_q            <= bram_di;
                dop_q           <= bram_dip;
            end else begin
                do_q  <= mem[bram_addr];
                dop_q <= pmem[bram_addr];
            end
        end
    end

    assign bram_do  = do_q;
    assign bram_dop = force_en ? force_dop : dop_q;

    bram_arbiter #(.ADDR_W(9), .DATA_W(32), .RR(1'b1)) u_rr (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1), .perr0(perr0), .perr1(perr1),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_di(bram_di), .bram_dip(bram_dip),
        .bram_do(bram_do), .bram_dop(bram_dop)
    );

    logic        f_req0, f_req1;
    logic        f_we;
    logic [8:0]  f_addr;
    logic [31:0] f_wdata;
    logic [31:0] f_do;
    logic [3:0]  f_dop;
    logic        f_gnt0, f_gnt1, f_done0, f_done1, f_perr0, f_perr1;
    logic [31:0] f_rdata0, f_rdata1;
    logic        f_en, f_bwe;
    logic [8:0]  f_baddr;
    logic [31:0] f_di;
    logic [3:0]  f_dip;

    assign f_we    = 1'b0;
    assign f_addr  = 9'd0;
    assign f_wdata = 32'd0;
    assign f_do    = 32'd0;
    assign f_dop   = 4'd0;

    bram_arbiter #(.ADDR_W(9), .DATA_W(32), .RR(1'b0)) u_fp (
        .clk(clk), .rst(rst),
        .req0(f_req0), .req1(f_req1), .we0(f_we), .we1(f_we),
        .addr0(f_addr), .addr1(f_addr), .wdata0(f_wdata), .wdata1(f_wdata),
        .gnt0(f_gnt0), .gnt1(f_gnt1), .done0(f_done0), .done1(f_done1),
        .rdata0(f_rdata0), .rdata1(f_rdata1), .perr0(f_perr0), .perr1(f_perr1),
        .bram_en(f_en), .bram_we(f_bwe), .bram_addr(f_baddr),
        .bram_di(f_di), .bram_dip(f_dip),
        .bram_do(f_do), .bram_dop(f_dop)
    );

    int          n_chk = 0;
    int          n_err = 0;
    logic [3:0]  dip_g;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acc(input bit p, input bit w, input logic [8:0] a,
                       input logic [31:0] d, input string tag);
        if (p) begin
            req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
        end
        tick();
        chk({tag, "_gnt"}, p ? gnt1 : gnt0, 1);
        dip_g = bram_dip;
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();
        chk({tag, "_done"}, p ? done1 : done0, 1);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem[i]  = 32'd0;
            pmem[i] = 4'd0;
        end
        do_q = 32'd0; dop_q = 4'd0;
        force_en = 1'b0; force_dop = 4'd0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        f_req0 = 0; f_req1 = 0;

        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_gnt", {gnt0, gnt1, done0, done1}, 0);
        chk("rst_en", {bram_en, bram_we, perr0, perr1}, 0);
        chk("rst_addr", bram_addr, 0);
        chk("rst_di", bram_di, 0);
        chk("rst_dip", bram_dip, 0);
        chk("rst_rd0", rdata0, 0);
        chk("rst_rd1", rdata1, 0);

        // port 0 write then port 1 read of the same word
        req0 = 1; we0 = 1; addr0 = 9'h005; wdata0 = 32'hDEADBEEF;
        tick();
        chk("w_gnt0", gnt0, 1);
        chk("w_gnt1", gnt1, 0);
        chk("w_en", {bram_en, bram_we}, 2'b11);
        chk("w_addr", bram_addr, 9'h005);
        chk("w_di", bram_di, 32'hDEADBEEF);
        req0 = 0;
        tick();
        chk("w_issue", {bram_en, gnt0, done0}, 0);
        tick();
        chk("w_done0", done0, 1);
        chk("w_rd0", rdata0, 0);
        req1 = 1; we1 = 0; addr1 = 9'h005;
        tick();
        chk("r_gnt1", gnt1, 1);
        chk("r_en", {bram_en, bram_we}, 2'b10);
        req1 = 0;
        tick();
        chk("r_nodone", done1, 0);
        tick();
        chk("r_done1", done1, 1);
        chk("r_rd1", rdata1, 32'hDEADBEEF);
        chk("r_perr1", perr1, 0);

        // simultaneous write (port 0) and read (port 1) of word 7
        req0 = 1; we0 = 1; addr0 = 9'h007; wdata0 = 32'h12345678;
        req1 = 1; we1 = 0; addr1 = 9'h007;
        tick();
        chk("t_gnt", {gnt0, gnt1}, 2'b10);
        req0 = 0;
        tick();
        tick();
        chk("t_cap", {done0, gnt1}, 2'b11);
        req1 = 0;
        tick();
        tick();
        chk("t_done1", done1, 1);
        chk("t_rd1", rdata1, 32'h12345678);

        // saturated round robin from reset
        rst = 1;
        tick();
        rst = 0;
        req0 = 1; we0 = 0; addr0 = 9'h005;
        req1 = 1; we1 = 0; addr1 = 9'h007;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("rr_gnt_%0d", i), {gnt0, gnt1},
                {1'(i % 4 == 1), 1'(i % 4 == 3)});
            chk($sformatf("rr_done_%0d", i), {done0, done1},
                {1'(i % 4 == 3), 1'((i % 4 == 1) && (i > 1))});
        end
        chk("rr_rd0", rdata0, 32'hDEADBEEF);
        chk("rr_rd1", rdata1, 32'h12345678);
        req0 = 0; req1 = 0;
        tick(); tick(); tick();

        // fixed priority: port 1 starves
        f_req0 = 1; f_req1 = 1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("fp_gnt_%0d", i), {f_gnt0, f_gnt1}, {1'(i % 2 == 1), 1'b0});
        end
        f_req0 = 0; f_req1 = 0;
        tick(); tick(); tick();

        // reset while a port 0 read is in ISSUE
        req0 = 1; we0 = 0; addr0 = 9'h007;
        tick();
        chk("ab_gnt0", gnt0, 1);
        req0 = 0;
        rst = 1;
        tick();
        chk("ab_out", {gnt0, gnt1, done0, done1, bram_en, bram_we}, 0);
        chk("ab_rd0", rdata0, 0);
        chk("ab_addr", bram_addr, 0);
        rst = 0;
        tick();
        chk("ab_nodone", done0, 0);
        req0 = 1; req1 = 1; we0 = 0; we1 = 0;
        tick();
        chk("ab_tie", {gnt0, gnt1}, 2'b10);
        req0 = 0; req1 = 0;
        tick(); tick();
        chk("ab_done0", done0, 1);
        tick();

        // request withdrawn before it is sampled
        req1 = 1;
        #3;
        req1 = 0;
        tick();
        chk("wd_idle", {bram_en, gnt1}, 0);
        tick(); tick();
        chk("wd_nodone", done1, 0);

        // parity generation and check
        acc(1'b0, 1'b1, 9'h009, 32'h00000000, "pz");
        chk("dip_zero", dip_g, 0);
        acc(1'b0, 1'b1, 9'h00A, 32'h01030007, "pw");
        chk("dip_pat", dip_g, PAR ? 4'b1001 : 4'b0000);
        force_en = 1; force_dop = 4'b0001;
        acc(1'b1, 1'b0, 9'h009, 32'h0, "pbad");
        chk("perr_bad", perr1, PAR);
        chk("pbad_rd1", rdata1, 32'h0);
        force_en = 0;
        tick();
        chk("perr_pulse", perr1, 0);
        acc(1'b1, 1'b0, 9'h00A, 32'h0, "pok");
        chk("perr_ok", perr1, 0);
        chk("pok_rd1", rdata1, 32'h01030007);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
